alu_out_capture: RTL and testbench



---
 rtl/alu_out_capture_pkg.sv | 16 +
 rtl/alu_out_capture_mux_n.sv | 27 ++
 rtl/alu_out_capture.sv | 113 +++++++++++
 tb/tb_alu_out_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_out_capture_pkg.sv
// Shared types and constants for the ALUOut capture path: FSM state encoding
// and the error codes reported back to the control FSM.
package alu_out_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_SEL     = 2'b01;
    localparam err_code_t ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/alu_out_capture_mux_n.sv
// Parametrised N:1 selector over a flattened source bus. An out-of-range
// select yields zero data and deasserted valid.
module mux_n #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] data,
    input  logic [NUM_SRC-1:0]       valid,
    output logic [WIDTH-1:0]         data_sel,
    output logic                     valid_sel
);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        data_sel  = '0;
        valid_sel = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                data_sel  = data[i*WIDTH +: WIDTH];
                valid_sel = valid[i];
            end
        end
    end

endmodule

// File: rtl/alu_out_capture.sv
// ALUOut source select and capture register: waits for the selected source to
// report valid, then latches it, with abort, bad-selector and timeout handling.
module alu_out_capture
    import alu_out_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic                     abort,
    output logic [WIDTH-1:0]         result,
    output logic                     done,
    output logic                     busy,
    output logic                     err,
    output err_code_t                err_code
);

    // One extra bit so NUM_SRC == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0] NUM_SRC_V  = (SEL_W+1)'(NUM_SRC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN            = (TIMEOUT != 0);

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mux_data;
    logic             mux_valid;
    logic             sel_bad;

    assign sel_bad = ({1'b0, sel} >= NUM_SRC_V);

    mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .sel       (sel_q),
        .data      (src_data),
        .valid     (src_valid),
        .data_sel  (mux_data),
        .valid_sel (mux_valid)
    );

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            cnt      <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort is ignored here, so start+abort is a plain start.
                    if (start) begin
                        sel_q    <= sel;
                        cnt      <= '0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        if (sel_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_SEL;
                            done     <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (mux_valid) begin
                        result <= mux_data;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                    end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else if (cnt != '1) begin
                        // Saturates at all-ones, which only matters when timeout is disabled.
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_out_capture.sv
// Randomised bench for alu_out_capture: a transaction-level model predicts the
// outcome (abort, capture or timeout) of each request from its timing alone.
module tb_alu_out_capture;
    import alu_out_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 63;
    localparam int TMO3 = 5;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic            start = 1'b0;
    logic [1:0]      sel = '0;
    logic [4*W-1:0]  src_data = '0;
    logic [3:0]      src_valid = '0;
    logic            abort = 1'b0;
    logic [W-1:0]    result;
    logic            done, busy, err;
    err_code_t       err_code;

    // Three-source instance with a short timeout
    logic            start3 = 1'b0;
    logic [1:0]      sel3 = '0;
    logic [3*W-1:0]  src_data3 = '0;
    logic [2:0]      src_valid3 = '0;
    logic            abort3 = 1'b0;
    logic [W-1:0]    result3;
    logic            done3, busy3, err3;
    err_code_t       err_code3;

    alu_out_capture #(.WIDTH(W), .NUM_SRC(4), .SEL_W(2), .TIMEOUT(TMO), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .src_data(src_data),
        .src_valid(src_valid), .abort(abort), .result(result), .done(done),
        .busy(busy), .err(err), .err_code(err_code)
    );

    alu_out_capture #(.WIDTH(W), .NUM_SRC(3), .SEL_W(2), .TIMEOUT(TMO3), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .sel(sel3), .src_data(src_data3),
        .src_valid(src_valid3), .abort(abort3), .result(result3), .done(done3),
        .busy(busy3), .err(err3), .err_code(err_code3)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Expected architectural state of the default instance
    logic [W-1:0] exp_result = '0;
    logic         exp_err = 1'b0;
    logic [1:0]   exp_code = 2'b00;
    bit           rand_data = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        if (rand_data)
            for (int i = 0; i < 4; i++) src_data[i*W +: W] = $urandom;
    endtask

    // One request on the default instance. k: WAIT cycle where src_valid[s]
    // rises (0 = never); a: WAIT cycle carrying abort (0 = never).
    task automatic run_txn(input int s, input int k, input int a, input bit hold, input bit ab_start);
        int nv, na, n, kind;
        logic [W-1:0] cap;
        nv = (k == 0) ? NEVER : k;
        na = (a == 0) ? NEVER : a;
        if (na <= nv && na <= TMO) begin kind = 0; n = na; end
        else if (nv <= TMO)        begin kind = 1; n = nv; end
        else                       begin kind = 2; n = TMO; end
        cap = '0;

        start = 1'b1;
        sel = 2'(s);
        abort = ab_start;
        src_valid = 4'($urandom);
        src_valid[s] = (nv == 1);
        drive_data();
        step();
        for (int w = 1; w <= n; w++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || result !== exp_result) begin
                n_mis++;
                $display("FAIL wait_cycle%0d sel=%0d: busy=%b done=%b result=%h, required busy=1 done=0 result=%h",
                         w, s, busy, done, result, exp_result);
            end
            start = hold;
            if (hold) sel = 2'($urandom_range(0, 3));
            abort = (w == na);
            src_valid = 4'($urandom);
            src_valid[s] = (w >= nv);
            drive_data();
            cap = src_data[s*W +: W];
            step();
        end
        start = 1'b0;
        abort = 1'b0;

        exp_err = 1'b0;
        exp_code = 2'b00;
        if (kind == 1) exp_result = cap;
        if (kind == 2) begin exp_err = 1'b1; exp_code = 2'b10; end

        n_vec++;
        if (done !== (kind != 0) || busy !== 1'b0 || result !== exp_result ||
            err !== exp_err || err_code !== exp_code) begin
            n_mis++;
            $display("FAIL end_kind%0d sel=%0d: done=%b busy=%b result=%h err=%b code=%b, required done=%b busy=0 result=%h err=%b code=%b",
                     kind, s, done, busy, result, err, err_code, kind != 0, exp_result, exp_err, exp_code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_dut: result=%h done=%b busy=%b err=%b code=%b, required all zero",
                     result, done, busy, err, err_code);
        end
        n_vec++;
        if (result3 !== '0 || done3 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b0 || err_code3 !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_dut3: result=%h done=%b busy=%b err=%b code=%b, required all zero",
                     result3, done3, busy3, err3, err_code3);
        end
        reset = 1'b0;
        exp_result = '0;
        exp_err = 1'b0;
        exp_code = 2'b00;
    endtask

    task automatic test_basic();
        rand_data = 1'b0;
        src_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        run_txn(2, 1, 0, 1'b0, 1'b0);
        n_vec++;
        if (result !== 32'hCCCC0002) begin
            n_mis++;
            $display("FAIL basic_value: result=%h, required cccc0002", result);
        end
        step();
        n_vec++;
        if (done !== 1'b0 || result !== 32'hCCCC0002) begin
            n_mis++;
            $display("FAIL basic_done_pulse: done=%b result=%h, required done=0 result=cccc0002", done, result);
        end
        // valid raised 5 cycles after start
        src_data[1*W +: W] = 32'h0000_00FF;
        run_txn(1, 5, 0, 1'b0, 1'b0);
        n_vec++;
        if (result !== 32'h0000_00FF || err !== 1'b0) begin
            n_mis++;
            $display("FAIL delayed_valid: result=%h err=%b, required 000000ff err=0", result, err);
        end
        rand_data = 1'b1;
    endtask

    task automatic test_timeout();
        run_txn(3, 0, 0, 1'b0, 1'b0);
        run_txn(3, TMO, 0, 1'b0, 1'b0);
        run_txn(0, TMO, TMO, 1'b0, 1'b0);
    endtask

    task automatic test_abort_reset();
        run_txn(0, 1, 0, 1'b0, 1'b0);
        run_txn(2, 0, 3, 1'b0, 1'b0);
        run_txn(1, 4, 4, 1'b0, 1'b0);
        run_txn(3, 2, 0, 1'b0, 1'b1);
        // reset asserted in WAIT cycle 2 of a pending capture
        start = 1'b1;
        sel = 2'd1;
        src_valid = 4'b0000;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        src_valid = 4'b1111;
        step();
        reset = 1'b0;
        exp_result = '0;
        n_vec++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_mid_wait: result=%h done=%b busy=%b err=%b code=%b, required all zero",
                     result, done, busy, err, err_code);
        end
        src_valid = 4'b0000;
        step();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(3, 4, 0, 1'b1, 1'b0);
        run_txn(0, 6, 0, 1'b1, 1'b0);
        run_txn(1, 1, 0, 1'b0, 1'b0);
        run_txn(2, 1, 0, 1'b0, 1'b0);
        run_txn(0, 0, 2, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int k, a;
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0;
            run_txn($urandom_range(0, 3), k, a, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_bad_sel();
        logic [W-1:0] d;
        start3 = 1'b1;
        sel3 = 2'd3;
        src_valid3 = 3'b111;
        step();
        start3 = 1'b0;
        n_vec++;
        if (done3 !== 1'b1 || err3 !== 1'b1 || err_code3 !== 2'b01 || busy3 !== 1'b0 || result3 !== '0) begin
            n_mis++;
            $display("FAIL bad_sel: done=%b err=%b code=%b busy=%b result=%h, required 1 1 01 0 0",
                     done3, err3, err_code3, busy3, result3);
        end
        step();
        n_vec++;
        if (done3 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b1) begin
            n_mis++;
            $display("FAIL bad_sel_hold: done=%b busy=%b err=%b, required 0 0 1", done3, busy3, err3);
        end
        // good start clears the sticky error
        d = $urandom;
        src_data3[1*W +: W] = d;
        src_valid3 = 3'b000;
        start3 = 1'b1;
        sel3 = 2'd1;
        step();
        start3 = 1'b0;
        src_valid3 = 3'b010;
        n_vec++;
        if (err3 !== 1'b0 || err_code3 !== 2'b00 || busy3 !== 1'b1) begin
            n_mis++;
            $display("FAIL good_after_bad: err=%b code=%b busy=%b, required 0 00 1", err3, err_code3, busy3);
        end
        step();
        n_vec++;
        if (done3 !== 1'b1 || result3 !== d || err3 !== 1'b0) begin
            n_mis++;
            $display("FAIL good_capture3: done=%b result=%h err=%b, required 1 %h 0", done3, result3, err3, d);
        end
        // short timeout on the three-source instance
        src_valid3 = 3'b000;
        start3 = 1'b1;
        sel3 = 2'd0;
        step();
        start3 = 1'b0;
        for (int w = 1; w < TMO3; w++) step();
        n_vec++;
        if (busy3 !== 1'b1 || done3 !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout3_early: busy=%b done=%b, required 1 0", busy3, done3);
        end
        step();
        n_vec++;
        if (done3 !== 1'b1 || err3 !== 1'b1 || err_code3 !== 2'b10 || result3 !== d || busy3 !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout3: done=%b err=%b code=%b result=%h busy=%b, required 1 1 10 %h 0",
                     done3, err3, err_code3, result3, busy3, d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_abort_reset();
        test_back_to_back();
        test_random();
        test_bad_sel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
